decimal_to_c2_encoder: RTL and testbench
========================================

Name: decimal_to_c2_encoder

Overview:
- Inverse of the existing two's-complement-to-decimal converter.
- Accepts a signed decimal number as sign plus hundreds/tens/units digits.
- Produces the DW-bit two's-complement word and flags digits or magnitudes that cannot be represented.
- Multi-cycle: valid/ready in, Horner multiply-by-10 accumulation over 3 cycles, range check, valid/ready out. Sits between keypad/UI digit entry and datapath logic.

Parameters:
- DW, 8: width of the two's-complement result and of each digit port; legal range 4..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sign and digit inputs are valid.
- in_ready  output  1  block can accept an input.
- sign  input  1  1 = negative.
- hundreds  input  DW  hundreds digit; only 0..9 is legal.
- tens  input  DW  tens digit; only 0..9 is legal.
- units  input  DW  units digit; only 0..9 is legal.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- complement2  output  DW  two's-complement result.
- out_err  output  1  illegal digit or magnitude out of range.

Behaviour:
- Clocking and reset: one clock domain (clk). rst is asynchronous, active-high.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, complement2 = 0, out_err = 0, accumulator = 0, step counter = 0.
- Reset mid-operation: in-flight data is discarded and the block returns to IDLE with the reset values above. No output is produced for that transaction.
- FSM states: IDLE, CALC, CHECK, OUT.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid && in_ready, capture sign and the three digits. Clear the accumulator and the step counter. Go to CALC.
- CALC:
  - Three cycles; step counter 0,1,2 selects hundreds, tens, units.
  - Each cycle: acc <= acc*10 + digit, computed as (acc<<3)+(acc<<1)+digit. No multiplier or divider is inferred.
  - Any digit > 9 sets a sticky digit_err.
  - After step 2, go to CHECK.
- Accumulator width: ACC_W = 10, which holds the maximum magnitude 999. Digits are zero-extended and truncated to 4 bits only after the >9 check.
- CHECK, one cycle. Let M = acc.
  - Range error if sign = 0 and M > 2^(DW-1)-1.
  - Range error if sign = 1 and M > 2^(DW-1).
  - If digit_err or range error: complement2 <= 0, out_err <= 1.
  - Otherwise complement2 <= sign ? (~M[DW-1:0] + 1) : M[DW-1:0], and out_err <= 0.
  - Negative zero (sign = 1, M = 0) gives 0 with no error.
  - For DW ≥ 11 no range error is possible; the check still exists.
  - Go to OUT.
- OUT:
  - out_valid = 1; complement2 and out_err are held stable.
  - On out_valid && out_ready, go to IDLE. out_valid drops and in_ready rises in the next cycle; there is no same-cycle bypass.
  - In all other states out_valid = 0. complement2 and out_err hold their last value until the next CHECK or a reset.
- Latency: out_valid is visible after the 4th rising edge following the accepting edge (3 CALC + 1 CHECK).
- Throughput: at most one transaction per 6 cycles when out_ready is held at 1.
- in_valid while in_ready = 0 is ignored. Inputs do not need to be held after acceptance.
- out_ready while out_valid = 0 has no effect.

Decomposition:
- Package c2_dec_pkg holds:
  - state enum {IDLE, CALC, CHECK, OUT};
  - DEC_RADIX = 10, MAX_DIGIT = 9, NUM_DIGITS = 3, ACC_W = 10.
- Sub-module dec_mac10: combinational acc*10 + digit using shifts and adds. Ports: acc_in[ACC_W], digit[4], acc_out[ACC_W]. Instantiated once in CALC.

Test Plan:
- Largest positive: sign=0, 1/2/7, out_ready=1 -> complement2 = 0x7F, out_err = 0; out_valid 4 edges after acceptance, high for exactly 1 cycle.
- Negative extremes: sign=1, 1/2/8 -> 0x80, err 0. sign=1, 0/0/1 -> 0xFF, err 0. sign=1, 0/0/0 -> 0x00, err 0.
- Range errors: sign=0, 1/2/8 -> 0x00, err 1. sign=1, 1/2/9 -> 0x00, err 1. sign=0, 9/9/9 -> 0x00, err 1.
- Illegal digit: sign=0, 0/10/3 -> err 1, complement2 = 0. A following legal input 0/4/2 -> 0x2A, err 0, so no sticky error leaks across transactions.
- Backpressure and overlap:
  - out_ready low 5 cycles -> out_valid, 0x7F and err held stable throughout.
  - A second in_valid during CALC/CHECK/OUT is not accepted (in_ready = 0).
  - in_ready returns 1 the cycle after the handshake.
- Reset mid-CALC: assert rst on the 2nd CALC cycle -> out_valid stays 0, complement2 = 0, in_ready = 1 immediately. The next input 0/9/9 -> 0x63.

Source files
------------

// File: rtl/c2_dec_pkg.sv
// Shared types and constants for the decimal-to-two's-complement encoder.
// The accumulator is sized for the largest three-digit magnitude (999).
package c2_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CHECK = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEC_RADIX  = 10;
  localparam int MAX_DIGIT  = 9;
  localparam int NUM_DIGITS = 3;
  localparam int ACC_W      = 10;

endpackage

// File: rtl/dec_mac10.sv
// Combinational acc*10 + digit built from two shifts and adds, so no
// multiplier is inferred.
module dec_mac10
  import c2_dec_pkg::*;
(
  input  logic [ACC_W-1:0] acc_in,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_out
);

  assign acc_out = (acc_in << 3) + (acc_in << 1) + {{(ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/decimal_to_c2_encoder.sv
// Sign + three BCD-style digits in, DW-bit two's-complement word out.
// Horner accumulation over three cycles, one range-check cycle, then a held result.
module decimal_to_c2_encoder
  import c2_dec_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sign,
  input  logic [DW-1:0] hundreds,
  input  logic [DW-1:0] tens,
  input  logic [DW-1:0] units,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] complement2,
  output logic          out_err
);

  localparam logic [31:0]   POS_LIMIT   = (32'd1 << (DW - 1)) - 32'd1;
  localparam logic [31:0]   NEG_LIMIT   = 32'd1 << (DW - 1);
  localparam logic [DW-1:0] DIGIT_LIMIT = DW'(MAX_DIGIT);
  localparam logic [1:0]    LAST_STEP   = 2'(NUM_DIGITS - 1);

  state_t                state_reg, state_next;
  logic                  sign_reg;
  logic [DW-1:0]         dig_in  [NUM_DIGITS];
  logic [DW-1:0]         dig_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dig_bad;
  logic [ACC_W-1:0]      acc_reg;
  logic [ACC_W-1:0]      acc_next;
  logic [1:0]            step_reg;
  logic                  digit_err_reg;
  logic [DW-1:0]         complement2_reg;
  logic                  out_err_reg;
  logic [DW-1:0]         digit_cur;
  logic                  digit_bad_cur;
  logic [DW-1:0]         mag_dw;
  logic                  range_err;

  assign dig_in[0] = hundreds;
  assign dig_in[1] = tens;
  assign dig_in[2] = units;

  // Legality is judged on the full port width, before truncation to 4 bits.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig_chk
      assign dig_bad[gi] = (dig_reg[gi] > DIGIT_LIMIT);
    end
  endgenerate

  always_comb begin
    digit_cur     = dig_reg[0];
    digit_bad_cur = dig_bad[0];
    case (step_reg)
      2'd1: begin
        digit_cur     = dig_reg[1];
        digit_bad_cur = dig_bad[1];
      end
      2'd2: begin
        digit_cur     = dig_reg[2];
        digit_bad_cur = dig_bad[2];
      end
      default: ;
    endcase
  end

  dec_mac10 u_mac (
    .acc_in  (acc_reg),
    .digit   (digit_cur[3:0]),
    .acc_out (acc_next)
  );

  // Magnitude resized to the result width; narrow results keep only the low bits.
  generate
    if (DW > ACC_W) begin : g_mag_wide
      assign mag_dw = {{(DW-ACC_W){1'b0}}, acc_reg};
    end else if (DW == ACC_W) begin : g_mag_equal
      assign mag_dw = acc_reg;
    end else begin : g_mag_narrow
      assign mag_dw = acc_reg[DW-1:0];
    end
  endgenerate

  assign range_err = sign_reg ? (32'(acc_reg) > NEG_LIMIT)
                              : (32'(acc_reg) > POS_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (step_reg == LAST_STEP) state_next = CHECK;
      end
      CHECK: begin
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_reg        <= 1'b0;
      acc_reg         <= '0;
      step_reg        <= 2'd0;
      digit_err_reg   <= 1'b0;
      complement2_reg <= '0;
      out_err_reg     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) dig_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg      <= sign;
            acc_reg       <= '0;
            step_reg      <= 2'd0;
            digit_err_reg <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) dig_reg[i] <= dig_in[i];
          end
        end
        CALC: begin
          acc_reg       <= acc_next;
          step_reg      <= step_reg + 2'd1;
          digit_err_reg <= digit_err_reg | digit_bad_cur;
        end
        CHECK: begin
          if (digit_err_reg || range_err) begin
            complement2_reg <= '0;
            out_err_reg     <= 1'b1;
          end else begin
            complement2_reg <= sign_reg ? (~mag_dw + DW'(1)) : mag_dw;
            out_err_reg     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign complement2 = complement2_reg;
  assign out_err     = out_err_reg;

endmodule

// File: tb/tb_decimal_to_c2_encoder.sv
// Randomised and directed bench for decimal_to_c2_encoder, checked every
// cycle against an arithmetic model of the expected word, flag and latency.
module tb_decimal_to_c2_encoder;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          sign;
  logic [DW-1:0] hundreds;
  logic [DW-1:0] tens;
  logic [DW-1:0] units;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] complement2;
  logic          out_err;

  decimal_to_c2_encoder #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign        (sign),
    .hundreds    (hundreds),
    .tens        (tens),
    .units       (units),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .complement2 (complement2),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] c2;
    logic          err;
    int            due;
  } exp_t;

  exp_t          q[$];
  int            checks   = 0;
  int            errors   = 0;
  int            cyc      = 0;
  int            done_cnt = 0;
  bit            busy     = 1'b0;
  logic [DW-1:0] last_c2  = '0;
  logic          last_err = 1'b0;
  logic [DW-1:0] seen_c2  = '0;
  logic          seen_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected result straight from the decimal value and the representable range.
  function automatic void model(input logic s, input int h, input int t, input int u,
                                output logic [DW-1:0] c2, output logic err);
    int m;
    bit bad;
    m   = h * 100 + t * 10 + u;
    bad = (h > 9) || (t > 9) || (u > 9);
    if (s) bad = bad || (m > (1 << (DW - 1)));
    else   bad = bad || (m > (1 << (DW - 1)) - 1);
    if (bad) begin
      c2  = '0;
      err = 1'b1;
    end else begin
      c2  = s ? DW'(-m) : DW'(m);
      err = 1'b0;
    end
  endfunction

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [DW-1:0] mc;
    logic          me;
    bit            exp_v;
    cyc++;
    if (rst) begin
      q.delete();
      busy     = 1'b0;
      last_c2  = '0;
      last_err = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_c2", 32'(complement2), 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
    end else begin
      check("in_ready", 32'(in_ready), 32'(!busy));
      exp_v = (q.size() > 0) && (cyc >= q[0].due);
      check("out_valid", 32'(out_valid), 32'(exp_v));
      if (out_valid && q.size() > 0) begin
        check("c2", 32'(complement2), 32'(q[0].c2));
        check("err", 32'(out_err), 32'(q[0].err));
        if (out_ready) begin
          last_c2  = q[0].c2;
          last_err = q[0].err;
          seen_c2  = complement2;
          seen_err = out_err;
          void'(q.pop_front());
          busy = 1'b0;
          done_cnt++;
        end
      end else if (!busy) begin
        check("hold_c2", 32'(complement2), 32'(last_c2));
        check("hold_err", 32'(out_err), 32'(last_err));
      end
      if (in_valid && in_ready) begin
        model(sign, int'(hundreds), int'(tens), int'(units), mc, me);
        e.c2  = mc;
        e.err = me;
        e.due = cyc + 5;
        q.push_back(e);
        busy = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input int h, input int t, input int u);
    sign     = s;
    hundreds = DW'(h);
    tens     = DW'(t);
    units    = DW'(u);
  endtask

  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = in_ready;
      tick();
    end
    if (!ok) check({name, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int prev, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (done_cnt > prev) ok = 1'b1;
      else tick();
    end
    if (!ok) check({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_one(input logic s, input int h, input int t, input int u,
                         input logic [DW-1:0] exp_c2, input logic exp_err, input string name);
    int prev;
    prev      = done_cnt;
    out_ready = 1'b1;
    drive(s, h, t, u);
    in_valid = 1'b1;
    wait_accept(name);
    in_valid = 1'b0;
    wait_done(prev, name);
    check({name, "_c2"}, 32'(seen_c2), 32'(exp_c2));
    check({name, "_err"}, 32'(seen_err), 32'(exp_err));
    $display("txn %s: sign=%0d %0d/%0d/%0d -> c2=0x%0h err=%0d", name, s, h, t, u, seen_c2, seen_err);
  endtask

  typedef struct {
    logic          s;
    int            h, t, u;
    logic [DW-1:0] c2;
    logic          err;
    string         name;
  } vec_t;

  vec_t vecs[9] = '{
    '{1'b0, 1, 2, 7,  8'h7F, 1'b0, "pos_max"},
    '{1'b1, 1, 2, 8,  8'h80, 1'b0, "neg_max"},
    '{1'b1, 0, 0, 1,  8'hFF, 1'b0, "neg_one"},
    '{1'b1, 0, 0, 0,  8'h00, 1'b0, "neg_zero"},
    '{1'b0, 1, 2, 8,  8'h00, 1'b1, "pos_over"},
    '{1'b1, 1, 2, 9,  8'h00, 1'b1, "neg_over"},
    '{1'b0, 9, 9, 9,  8'h00, 1'b1, "pos_999"},
    '{1'b0, 0, 10, 3, 8'h00, 1'b1, "bad_digit"},
    '{1'b0, 0, 4, 2,  8'h2A, 1'b0, "after_bad"}
  };

  function automatic int rnd_digit();
    int r;
    r = $urandom_range(0, 19);
    if (r < 17) return r % 10;
    return $urandom_range(10, 255);
  endfunction

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DW-1:0] mc;
    logic          me;
    int            prev;
    bit            seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 0, 0, 0);

    // Model pinned against hand-computed values.
    model(1'b0, 1, 2, 7, mc, me); check("model_127", {23'd0, me, mc}, 32'h07F);
    model(1'b1, 1, 2, 8, mc, me); check("model_m128", {23'd0, me, mc}, 32'h080);
    model(1'b1, 0, 4, 2, mc, me); check("model_m42", {23'd0, me, mc}, 32'h0D6);
    model(1'b0, 3, 0, 0, mc, me); check("model_300", {23'd0, me, mc}, 32'h100);

    repeat (3) tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_one(vecs[i].s, vecs[i].h, vecs[i].t, vecs[i].u,
                              vecs[i].c2, vecs[i].err, vecs[i].name);

    // Backpressure with a competing request held on the input.
    prev      = done_cnt;
    out_ready = 1'b0;
    drive(1'b0, 1, 2, 7);
    in_valid = 1'b1;
    wait_accept("bp");
    drive(1'b1, 5, 5, 5);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (out_valid) seen = 1'b1;
      else begin
        check("bp_in_ready_busy", 32'(in_ready), 32'd0);
        tick();
      end
    end
    if (!seen) check("bp_valid_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_c2", 32'(complement2), 32'h7F);
      check("bp_err", 32'(out_err), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    wait_done(prev, "bp");
    $display("txn backpressure: c2=0x%0h err=%0d", seen_c2, seen_err);

    // Reset on the second CALC cycle discards the transaction.
    drive(1'b0, 1, 2, 3);
    in_valid = 1'b1;
    wait_accept("rst_mid");
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_c2", 32'(complement2), 32'd0);
    tick();
    rst = 1'b0;
    repeat (6) begin
      check("rstmid_no_out", 32'(out_valid), 32'd0);
      tick();
    end
    $display("txn reset_mid_calc: discarded");
    run_one(1'b0, 0, 9, 9, 8'h63, 1'b0, "after_rst");

    // Random traffic with random backpressure.
    for (int n = 0; n < 800; n++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), rnd_digit(), rnd_digit(), rnd_digit());
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    check("drain_empty", 32'(q.size()), 32'd0);
    $display("txn random: %0d results delivered", done_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
